// File: rtl/game_pkg.sv
// Shared definitions for the turn scheduler: FSM states, reply codes and
// the bit layout of a microcode byte.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_REPLY     = 3'd4
  } state_e;

  localparam logic [7:0] RPL_ACK    = 8'h06;
  localparam logic [7:0] RPL_PARITY = 8'h15;
  localparam logic [7:0] RPL_TURN   = 8'h16;
  localparam logic [7:0] RPL_ABORT  = 8'h17;

  // Microcode layout: {target, switch[2:0], turn[2:0], parity}
  localparam int MC_PARITY_BIT = 0;
  localparam int MC_TURN_LSB   = 1;
  localparam int MC_TURN_MSB   = 3;
  localparam int MC_SW_LSB     = 4;
  localparam int MC_SW_MSB     = 6;
  localparam int MC_TARGET_BIT = 7;

  // Even parity over the whole byte is valid; an odd XOR flags a bad byte.
  function automatic logic mc_parity_odd(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/timeout_timer.sv
// Down-counting watchdog for the move handshake. start loads CYCLES-1 so
// expired is high during the CYCLES-th cycle after the start pulse.
module timeout_timer #(
  parameter int CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;

  // Next-state: clear wins over start; count down to terminal count and hold.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (clear) begin
      cnt_d    = '0;
      active_d = 1'b0;
    end else if (start) begin
      cnt_d    = LOAD;
      active_d = 1'b1;
    end else if (active_q && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign expired = active_q && (cnt_q == '0);

endmodule

// File: rtl/turn_scheduler.sv
// Turn scheduler: accepts microcode bytes, validates them, issues moves to
// the game-state table and sends a one-byte reply per byte.
// Optional feature macro: TURN_SCHEDULER_PARITY_EN enables the parity check.
//
// state        | meaning
// IDLE         | waiting for a microcode byte (rx_ready=1)
// CHECK        | parity / expected-turn validation
// ISSUE        | arm timeout timer, one cycle before gt_req rises
// WAIT_DONE    | gt_req held until gt_ack or timeout
// REPLY        | tx_valid held until tx_ready
module turn_scheduler
  import game_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_TURN       = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       gt_req,
  output logic [2:0] gt_switch,
  output logic       gt_target,
  output logic [2:0] gt_turn,
  input  logic       gt_ack,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [2:0] exp_turn,
  output logic [7:0] err_cnt
);

  localparam logic [2:0] LAST_TURN = 3'(MAX_TURN);

  state_e     state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic [7:0] reply_q, reply_d;
  logic [2:0] exp_turn_q, exp_turn_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       tmr_start, tmr_clear, tmr_expired;
  logic       parity_bad;

`ifdef TURN_SCHEDULER_PARITY_EN
  assign parity_bad = mc_parity_odd(byte_q);
`else
  logic parity_unused;
  assign parity_unused = byte_q[MC_PARITY_BIT];
  assign parity_bad    = 1'b0;
`endif

  timeout_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (tmr_start),
    .clear   (tmr_clear),
    .expired (tmr_expired)
  );

  // Next-state and datapath updates; gt_ack is only looked at in WAIT_DONE.
  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    reply_d    = reply_q;
    exp_turn_d = exp_turn_q;
    err_cnt_d  = err_cnt_q;
    tmr_start  = 1'b0;
    tmr_clear  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          byte_d  = rx_data;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (parity_bad) begin
          reply_d = RPL_PARITY;
          state_d = ST_REPLY;
        end else if (byte_q[MC_TURN_MSB:MC_TURN_LSB] != exp_turn_q) begin
          reply_d = RPL_TURN;
          state_d = ST_REPLY;
        end else begin
          state_d = ST_ISSUE;
        end
        if (state_d == ST_REPLY && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
      ST_ISSUE: begin
        tmr_start = 1'b1;
        state_d   = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (gt_ack) begin
          reply_d    = RPL_ACK;
          exp_turn_d = (exp_turn_q == LAST_TURN) ? 3'd0 : exp_turn_q + 3'd1;
          tmr_clear  = 1'b1;
          state_d    = ST_REPLY;
        end else if (tmr_expired) begin
          reply_d   = RPL_ABORT;
          tmr_clear = 1'b1;
          state_d   = ST_REPLY;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      ST_REPLY: begin
        if (tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      byte_q     <= '0;
      reply_q    <= '0;
      exp_turn_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      reply_q    <= reply_d;
      exp_turn_q <= exp_turn_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign rx_ready  = (state_q == ST_IDLE);
  assign gt_req    = (state_q == ST_WAIT_DONE);
  assign gt_switch = byte_q[MC_SW_MSB:MC_SW_LSB];
  assign gt_target = byte_q[MC_TARGET_BIT];
  assign gt_turn   = byte_q[MC_TURN_MSB:MC_TURN_LSB];
  assign tx_valid  = (state_q == ST_REPLY);
  assign tx_data   = tx_valid ? reply_q : 8'h00;
  assign exp_turn  = exp_turn_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Scoreboard bench for turn_scheduler: the expected reply for each byte is
// queued when the byte is driven and checked when the reply handshakes.
module tb_turn_scheduler;

  localparam int TO = 10;
  localparam int MT = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic       gt_req;
  logic [2:0] gt_switch;
  logic       gt_target;
  logic [2:0] gt_turn;
  logic       gt_ack = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [2:0] exp_turn;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  turn_scheduler #(.TIMEOUT_CYCLES(TO), .MAX_TURN(MT)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .gt_req    (gt_req),
    .gt_switch (gt_switch),
    .gt_target (gt_target),
    .gt_turn   (gt_turn),
    .gt_ack    (gt_ack),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .exp_turn  (exp_turn),
    .err_cnt   (err_cnt)
  );

  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] sb_q[$];
  logic [2:0] m_exp = '0;
  logic [7:0] m_err = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] mk(input logic tgt, input logic [2:0] sw,
                                    input logic [2:0] trn, input logic par_ok);
    logic [7:0] b;
    b    = {tgt, sw, trn, 1'b0};
    b[0] = par_ok ? ^b[7:1] : ~(^b[7:1]);
    return b;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_exp = '0;
    m_err = '0;
    sb_q.delete();
  endtask

  // ack_dly < 0 means gt_ack is never raised; hold = cycles tx_ready stays low.
  task automatic do_move(input logic [7:0] b, input int ack_dly, input int hold);
    logic [7:0] rpl;
    logic [7:0] seen;
    logic       par_bad;
    bit         issue;
    int         k;
    issue = 0;
`ifdef TURN_SCHEDULER_PARITY_EN
    par_bad = ^b;
`else
    par_bad = 1'b0;
`endif
    if (par_bad) rpl = 8'h15;
    else if (b[3:1] != m_exp) rpl = 8'h16;
    else begin
      issue = 1;
      rpl = (ack_dly < 0 || ack_dly >= TO) ? 8'h17 : 8'h06;
    end
    sb_q.push_back(rpl);

    @(negedge clk);
    chk("rx_ready_idle", rx_ready, 1);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("gt_req_c1", gt_req, 0);
    @(negedge clk);
    chk("gt_req_c2", gt_req, 0);
    @(negedge clk);
    if (issue) begin
      chk("gt_req_c3", gt_req, 1);
      chk("gt_switch", gt_switch, b[6:4]);
      chk("gt_target", gt_target, b[7]);
      chk("gt_turn", gt_turn, b[3:1]);
      if (ack_dly >= 0 && ack_dly < TO) begin
        repeat (ack_dly) @(negedge clk);
        chk("gt_switch_hold", gt_switch, b[6:4]);
        gt_ack = 1'b1;
        @(negedge clk);
        gt_ack = 1'b0;
        chk("gt_req_drop", gt_req, 0);
      end else begin
        k = 0;
        while (gt_req && k < 2 * TO) begin
          k++;
          @(negedge clk);
        end
        chk("gt_req_len", k, TO);
      end
    end else begin
      chk("gt_req_reject", gt_req, 0);
    end

    k = 0;
    while (!tx_valid && k < 20) begin
      k++;
      @(negedge clk);
    end
    if (!tx_valid) begin
      chk("tx_valid_wait", 0, 1);
      void'(sb_q.pop_front());
      return;
    end
    seen = tx_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("tx_valid_hold", tx_valid, 1);
      chk("tx_data_hold", tx_data, seen);
      chk("rx_ready_hold", rx_ready, 0);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    chk("reply", seen, sb_q.pop_front());

    if (rpl == 8'h06) m_exp = (m_exp == 3'(MT)) ? 3'd0 : m_exp + 3'd1;
    else if (m_err != 8'hFF) m_err = m_err + 8'd1;
    chk("tx_valid_done", tx_valid, 0);
    chk("exp_turn", exp_turn, m_exp);
    chk("err_cnt", err_cnt, m_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    #1;
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_gt_req", gt_req, 0);
    chk("rst_gt_switch", gt_switch, 0);
    chk("rst_gt_target", gt_target, 0);
    chk("rst_gt_turn", gt_turn, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_exp_turn", exp_turn, 0);
    chk("rst_err_cnt", err_cnt, 0);

    // turn 0, switch 1, even parity, ack after 3 cycles
    do_move(8'b0001_0001, 3, 0);

    // odd parity byte: rejected with parity enabled, otherwise issued
    do_reset();
    do_move(8'h01, 2, 0);

    // wrong turn with good parity
    do_reset();
    do_move(8'h06, 0, 0);

    // timeout, then ack on the final cycle
    do_move(8'h21, -1, 0);
    do_move(8'h21, TO - 1, 0);

    // gt_ack outside WAIT_DONE must be ignored
    @(negedge clk);
    gt_ack = 1'b1;
    repeat (2) @(negedge clk);
    gt_ack = 1'b0;
    chk("ack_idle_exp", exp_turn, m_exp);
    chk("ack_idle_tx", tx_valid, 0);

    // eight valid moves, exp_turn wraps through MAX_TURN; one held reply
    for (int i = 0; i < 8; i++) begin
      logic [2:0] iv;
      iv = 3'(i);
      do_move(mk(iv[0], iv, m_exp, 1'b1), i % 3, (i == 3) ? 5 : 0);
    end

    // bad parity with matching turn
    do_move(mk(1'b1, 3'd5, m_exp, 1'b0), 1, 0);

    // reset while waiting for gt_ack
    @(negedge clk);
    rx_data  = mk(1'b0, 3'd2, m_exp, 1'b1);
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_gt_req", gt_req, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_gt_req", gt_req, 0);
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_exp_turn", exp_turn, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    chk("mid_rst_rx_ready", rx_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_exp = '0;
    m_err = '0;
    repeat (3) @(negedge clk);
    chk("post_rst_tx_valid", tx_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/turn_scheduler.md
TURN_SCHEDULER -- requirements
Module: turn_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000, max cycles to wait for gt_ack before aborting.
REQ-002 SHALL have parameter MAX_TURN, default 7, last turn value before the expected-turn counter wraps to 0.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port rx_data, input, 8, microcode byte from UART receiver.
REQ-006 SHALL have port rx_valid, input, 1, rx_data valid this cycle.
REQ-007 SHALL have port rx_ready, output, 1, scheduler can accept a byte.
REQ-008 SHALL have port gt_req, output, 1, move request to the game-state table.
REQ-009 SHALL have port gt_switch, output, 3, switch index of the move.
REQ-010 SHALL have port gt_target, output, 1, targeted player.
REQ-011 SHALL have port gt_turn, output, 3, turn number of the move.
REQ-012 SHALL have port gt_ack, input, 1, game-state table has applied the move.
REQ-013 SHALL have port tx_data, output, 8, reply byte to UART transmitter.
REQ-014 SHALL have port tx_valid, output, 1, tx_data valid.
REQ-015 SHALL have port tx_ready, input, 1, transmitter accepts tx_data.
REQ-016 SHALL have port exp_turn, output, 3, currently expected turn.
REQ-017 SHALL have port err_cnt, output, 8, rejected/aborted move count.

Function
REQ-018 SHALL decode microcode as: bit0 parity, bits3:1 turn, bits6:4 switch, bit7 target.
REQ-019 SHALL implement FSM IDLE -> CHECK -> ISSUE -> WAIT_DONE -> REPLY -> IDLE; CHECK may go directly to REPLY.
REQ-020 SHALL drive rx_ready=1 only in IDLE, and latch rx_data when rx_valid&&rx_ready.
REQ-021 SHALL, in CHECK, reject with code 8'h15 on odd parity (XOR of all 8 bits is 1).
REQ-022 SHALL, in CHECK, reject with code 8'h16 when turn != exp_turn; parity error takes priority.
REQ-023 SHALL assert gt_req exactly 2 cycles after byte acceptance for valid moves, holding gt_switch/gt_target/gt_turn stable until gt_ack or timeout.
REQ-024 SHALL, in WAIT_DONE, deassert gt_req on gt_ack, reply 8'h06, and advance exp_turn (MAX_TURN wraps to 0).
REQ-025 SHALL abort after TIMEOUT_CYCLES without gt_ack, deassert gt_req, reply 8'h17, and leave exp_turn unchanged.
REQ-026 SHALL give gt_ack precedence when it arrives on the timeout cycle.
REQ-027 SHALL hold tx_valid and tx_data in REPLY until tx_ready, then return to IDLE.
REQ-028 SHALL increment err_cnt on each 8'h15/8'h16/8'h17 reply, saturating at 255.
REQ-029 SHALL ignore gt_ack outside WAIT_DONE.

Reset
REQ-030 SHALL, on rst, go to IDLE with rx_ready=1 and all other outputs at 0 (gt_req, gt_switch, gt_target, gt_turn, tx_valid, tx_data, exp_turn, err_cnt), including mid-move; the move is dropped and no reply is sent.

Configuration
REQ-031 SHALL, when TURN_SCHEDULER_PARITY_EN is defined, perform the REQ-021 check; when undefined, bit0 is ignored and 8'h15 is never produced.

Structure
REQ-032 SHALL place the FSM state enum, reply codes (8'h06/15/16/17) and microcode field positions in shared package game_pkg.
REQ-033 SHALL implement the timeout counter as sub-module timeout_timer (start, clear, expired).

Verification
REQ-034 SHALL cover: rst, then byte 8'b0001_0001 (turn0, sw1, even parity), gt_ack after 3 cycles -> gt_req at cycle+2, gt_switch=1, tx 8'h06, exp_turn=1.
REQ-035 SHALL cover: byte with odd parity (8'h01) -> no gt_req, tx 8'h15, err_cnt=1; repeat with macro undefined -> move issued.
REQ-036 SHALL cover: exp_turn=0, byte with turn=3 and valid parity -> tx 8'h16, exp_turn stays 0.
REQ-037 SHALL cover: TIMEOUT_CYCLES=10 with gt_ack never asserted -> gt_req drops after 10 cycles, tx 8'h17; gt_ack on cycle 10 -> 8'h06.
REQ-038 SHALL cover: eight valid moves with MAX_TURN=7 -> exp_turn wraps 7->0; tx_ready held low 5 cycles -> tx_valid/tx_data stable and rx_ready=0.
REQ-039 SHALL cover: rst asserted during WAIT_DONE -> gt_req=0, tx_valid=0, exp_turn=0 immediately.
